// File: rtl/clk125_pll_ctrl_pkg.sv
// ============================================================================
// Module   : clk125_pll_ctrl_pkg
// Purpose  : Shared state encoding and timer sizing helper for clk125_pll_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk125_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // Width of a counter that must reach the largest of the supplied limits.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk125_pll_ctrl_sync2.sv
// ============================================================================
// Module   : clk125_pll_ctrl_sync2
// Purpose  : Two-flop synchronizer with asynchronous active-low reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk125_pll_ctrl_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/clk125_pll_ctrl.sv
// ============================================================================
// Module   : clk125_pll_ctrl
// Purpose  : PLL reset sequencer / lock qualifier with retry, fault and
//            loss-of-lock counting. Optional RUN-state loss filter enabled by
//            defining CLK125_PLL_CTRL_LOSS_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk125_pll_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 125000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8,
    parameter int GLITCH_CYCLES = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked_i,
    input  logic             force_relock_i,
    input  logic             clear_fault_i,
    output logic             pll_rst_o,
    output logic             sys_rst_n_o,
    output logic             ready_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] relock_count_o
);

    import clk125_pll_ctrl_pkg::*;

    // The shared timer doubles as the loss filter while in RUN, so it is
    // sized to cover the glitch window as well.
    localparam int TMR_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, GLITCH_CYCLES);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] c_rst_last    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_lock_last   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] c_stable_last = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] c_max_retry   = RTY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
`ifdef CLK125_PLL_CTRL_LOSS_FILTER_EN
    localparam logic [TMR_W-1:0] c_glitch_last = TMR_W'(GLITCH_CYCLES - 1);
`endif

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [RTY_W-1:0]   r_retry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pll_rst;
    logic               r_sys_rst_n;
    logic               r_ready;
    logic               r_fault;

    state_t             w_nxt_state;
    logic               w_lk_s;
    logic               w_restart;
    logic               w_timeout;
    logic               w_loss;
    logic               w_retry_clr;
    logic [RTY_W-1:0]   w_retry_inc;
    logic [TMR_W-1:0]   w_timer_nxt;

    clk125_pll_ctrl_sync2 u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (pll_locked_i),
        .o_q   (w_lk_s)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_restart   = 1'b0;
        w_timeout   = 1'b0;
        w_loss      = 1'b0;
        w_retry_clr = 1'b0;
        w_retry_inc = r_retry + RTY_W'(1);
        case (r_state)
            RESET_PLL: begin
                if (force_relock_i) begin
                    w_restart = 1'b1;
                end else if (r_timer == c_rst_last) begin
                    w_nxt_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (force_relock_i) begin
                    w_nxt_state = RESET_PLL;
                end else if (w_lk_s) begin
                    w_nxt_state = STABLE;
                end else if (r_timer == c_lock_last) begin
                    w_timeout   = 1'b1;
                    w_nxt_state = (w_retry_inc == c_max_retry) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                if (force_relock_i) begin
                    w_nxt_state = RESET_PLL;
                end else if (!w_lk_s) begin
                    w_nxt_state = WAIT_LOCK;
                end else if (r_timer == c_stable_last) begin
                    w_nxt_state = RUN;
                    w_retry_clr = 1'b1;
                end
            end
            RUN: begin
`ifdef CLK125_PLL_CTRL_LOSS_FILTER_EN
                w_loss = !w_lk_s && (r_timer == c_glitch_last);
`else
                w_loss = !w_lk_s;
`endif
                if (w_loss || force_relock_i) begin
                    w_nxt_state = RESET_PLL;
                end
            end
            FAULT: begin
                if (clear_fault_i) begin
                    w_nxt_state = RESET_PLL;
                    w_retry_clr = 1'b1;
                end
            end
            default: begin
                w_nxt_state = RESET_PLL;
            end
        endcase
    end

    // Timer restarts on every state change; in RUN it only counts lk_s-low
    // cycles when the loss filter is built in.
    always_comb begin
        w_timer_nxt = r_timer + TMR_W'(1);
        if ((w_nxt_state != r_state) || w_restart || (r_state == FAULT)) begin
            w_timer_nxt = '0;
        end else if (r_state == RUN) begin
`ifdef CLK125_PLL_CTRL_LOSS_FILTER_EN
            w_timer_nxt = w_lk_s ? '0 : (r_timer + TMR_W'(1));
`else
            w_timer_nxt = '0;
`endif
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RESET_PLL;
            r_timer     <= '0;
            r_retry     <= '0;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_timer <= w_timer_nxt;
            if (w_retry_clr) begin
                r_retry <= '0;
            end else if (w_timeout) begin
                r_retry <= w_retry_inc;
            end
            if (w_loss && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pll_rst   <= (w_nxt_state == RESET_PLL) || (w_nxt_state == FAULT);
            r_sys_rst_n <= (w_nxt_state == RUN);
            r_ready     <= (w_nxt_state == RUN);
            r_fault     <= (w_nxt_state == FAULT);
        end
    end

    assign pll_rst_o      = r_pll_rst;
    assign sys_rst_n_o    = r_sys_rst_n;
    assign ready_o        = r_ready;
    assign fault_o        = r_fault;
    assign relock_count_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_clk125_pll_ctrl.sv
// ============================================================================
// Module   : tb_clk125_pll_ctrl
// Purpose  : Self-checking bench for clk125_pll_ctrl with an in-bench
//            behavioural model (honours CLK125_PLL_CTRL_LOSS_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk125_pll_ctrl;

    localparam int RST_C   = 4;
    localparam int TMO     = 20;
    localparam int STB     = 8;
    localparam int MAXR    = 2;
    localparam int CW      = 2;
    localparam int GL      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FLT  = 4;

    localparam int S_PLLRST = 0;
    localparam int S_READY  = 1;
    localparam int S_FAULT  = 2;

`ifdef CLK125_PLL_CTRL_LOSS_FILTER_EN
    localparam int DROP_LAT = 2 + GL;
`else
    localparam int DROP_LAT = 3;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          lock    = 1'b0;
    logic          force_r = 1'b0;
    logic          clr     = 1'b0;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic          fault;
    logic [CW-1:0] cnt;

    int n_chk  = 0;
    int n_pass = 0;

    clk125_pll_ctrl #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR),
        .CNT_W         (CW),
        .GLITCH_CYCLES (GL)
    ) dut (
        .refclk         (clk),
        .rst_n          (rst_n),
        .pll_locked_i   (lock),
        .force_relock_i (force_r),
        .clear_fault_i  (clr),
        .pll_rst_o      (pll_rst),
        .sys_rst_n_o    (sys_rst_n),
        .ready_o        (ready),
        .fault_o        (fault),
        .relock_count_o (cnt)
    );

    always #4 clk = ~clk;

    // Model: phase, cycles already spent in it, failed attempts, losses,
    // consecutive low lock samples in RUN, and a 2-deep lock delay line.
    typedef struct packed {
        int   phase;
        int   t;
        int   tries;
        int   losses;
        int   low;
        logic s1;
        logic s2;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '0;
        r.phase = P_RST;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic lk_in, input logic frc, input logic clf);
        mdl_t n;
        logic lk;
        logic loss;
        n    = m;
        n.s1 = lk_in;
        n.s2 = m.s1;
        lk   = m.s2;
        n.t  = m.t + 1;
        loss = 1'b0;
        case (m.phase)
            P_RST: begin
                if (frc) n.t = 0;
                else if (m.t + 1 == RST_C) begin n.phase = P_WAIT; n.t = 0; end
            end
            P_WAIT: begin
                if (frc) begin n.phase = P_RST; n.t = 0; end
                else if (lk) begin n.phase = P_STB; n.t = 0; end
                else if (m.t + 1 == TMO) begin
                    n.tries = m.tries + 1;
                    n.phase = (n.tries == MAXR) ? P_FLT : P_RST;
                    n.t = 0;
                end
            end
            P_STB: begin
                if (frc) begin n.phase = P_RST; n.t = 0; end
                else if (!lk) begin n.phase = P_WAIT; n.t = 0; end
                else if (m.t + 1 == STB) begin n.phase = P_RUN; n.t = 0; n.tries = 0; end
            end
            P_RUN: begin
                n.t = 0;
`ifdef CLK125_PLL_CTRL_LOSS_FILTER_EN
                n.low = lk ? 0 : m.low + 1;
                loss  = (n.low >= GL);
`else
                loss  = !lk;
`endif
                if (loss) begin
                    n.losses = (m.losses < CNT_MAX) ? m.losses + 1 : CNT_MAX;
                    n.phase  = P_RST;
                    n.low    = 0;
                end else if (frc) begin
                    n.phase = P_RST;
                    n.low   = 0;
                end
            end
            P_FLT: begin
                n.t = 0;
                if (clf) begin n.phase = P_RST; n.tries = 0; end
            end
            default: n = mdl_reset();
        endcase
        return n;
    endfunction

    mdl_t m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= mdl_step(m, lock, force_r, clr);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model pll_rst_o",      32'(pll_rst),   32'(m.phase == P_RST || m.phase == P_FLT));
            chk("model sys_rst_n_o",    32'(sys_rst_n), 32'(m.phase == P_RUN));
            chk("model ready_o",        32'(ready),     32'(m.phase == P_RUN));
            chk("model fault_o",        32'(fault),     32'(m.phase == P_FLT));
            chk("model relock_count_o", 32'(cnt),       32'(m.losses));
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            S_PLLRST: return pll_rst;
            S_READY:  return ready;
            S_FAULT:  return fault;
            default:  return sys_rst_n;
        endcase
    endfunction

    // Counts rising edges until the selected output reads val; 300 = expired.
    task automatic edges_until(input int sel, input logic val, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sig(sel) !== val && n < 300);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pll_rst_o"},      32'(pll_rst),   32'd1);
        chk({tag, " sys_rst_n_o"},    32'(sys_rst_n), 32'd0);
        chk({tag, " ready_o"},        32'(ready),     32'd0);
        chk({tag, " fault_o"},        32'(fault),     32'd0);
        chk({tag, " relock_count_o"}, 32'(cnt),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int run;
        int exp_cnt [4];
        exp_cnt = '{1, 2, 3, 3};

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up: reset pulse, then lock 3 cycles after pll_rst falls.
        edges_until(S_PLLRST, 1'b0, n);
        chk("rst pulse length", 32'(n), 32'd4);
        repeat (3) @(negedge clk);
        lock = 1'b1;
        edges_until(S_READY, 1'b1, n);
        chk("lock edge to ready", 32'(n), 32'd11);
        chk("sys_rst_n with ready", 32'(sys_rst_n), 32'd1);

        // Four losses in RUN; counter saturates.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lock = 1'b0;
            edges_until(S_READY, 1'b0, n);
            chk("drop to ready low", 32'(n), 32'(DROP_LAT));
            @(negedge clk);
            lock = 1'b1;
            edges_until(S_READY, 1'b1, n);
            chk("relock count", 32'(cnt), 32'(exp_cnt[k]));
        end

        // Forced relock in RUN.
        @(negedge clk);
        force_r = 1'b1;
        @(posedge clk);
        #1;
        force_r = 1'b0;
        chk("force ready low", 32'(ready), 32'd0);
        n = 1;
        while (pll_rst === 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            if (pll_rst === 1'b1) n++;
            else break;
        end
        chk("force rst pulse length", 32'(n), 32'd4);
        chk("force count unchanged", 32'(cnt), 32'd3);

        // Two-cycle dropout while qualifying restarts the full window.
        repeat (3) @(negedge clk);
        lock = 1'b0;
        repeat (2) @(negedge clk);
        lock = 1'b1;
        edges_until(S_READY, 1'b1, n);
        chk("requalify after stable drop", 32'(n), 32'd11);
        chk("stable drop count unchanged", 32'(cnt), 32'd3);

`ifdef CLK125_PLL_CTRL_LOSS_FILTER_EN
        @(negedge clk);
        lock = 1'b0;
        repeat (5) @(negedge clk);
        lock = 1'b1;
        repeat (15) @(negedge clk);
        chk("short drop keeps ready", 32'(ready), 32'd1);
        lock = 1'b0;
        edges_until(S_READY, 1'b0, n);
        chk("long drop to ready low", 32'(n), 32'(2 + GL));
        @(negedge clk);
        lock = 1'b1;
        edges_until(S_READY, 1'b1, n);
`endif

        // Asynchronous reset mid-RUN, then no lock at all -> FAULT.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edges_until(S_FAULT, 1'b1, n);
        chk("cycles to fault", 32'(n), 32'd48);
        chk("fault holds pll_rst", 32'(pll_rst), 32'd1);
        @(negedge clk);
        force_r = 1'b1;
        @(negedge clk);
        force_r = 1'b0;
        repeat (4) @(negedge clk);
        chk("force ignored in fault", 32'(fault), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clear fault_o", 32'(fault), 32'd0);
        chk("clear restarts reset", 32'(pll_rst), 32'd1);

        // Randomised lock waveform with sparse force/clear pulses.
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (run == 0) begin
                lock = ($urandom_range(0, 3) != 0);
                run  = $urandom_range(1, 45);
            end
            run--;
            force_r = ($urandom_range(0, 199) == 0);
            clr     = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        force_r = 1'b0;
        clr     = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clk125_pll_ctrl.md
Name: clk125_pll_ctrl

Overview:
- Controller for the other end of the PLL rst/locked interface; runs on the free-running 125 MHz reference clock.
- Drives the PLL reset and synchronizes/qualifies the PLL locked output.
- Retries on lock timeout; distributes a qualified system reset and ready flag to downstream logic.
- Counts loss-of-lock events and latches a fault after repeated failed lock attempts.

Parameters:
- RST_CYCLES, 16: cycles pll_rst_o is held high per attempt (>=1)
- LOCK_TIMEOUT, 125000: cycles to wait for lock per attempt (1 ms @125 MHz)
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release
- MAX_RETRIES, 4: consecutive timed-out attempts before FAULT (>=1)
- CNT_W, 8: width of relock_count_o
- GLITCH_CYCLES, 8: loss-filter length; used only with the optional feature

Ports:
- refclk  in  1  reference clock, 125 MHz
- rst_n  in  1  asynchronous active-low reset
- pll_locked_i  in  1  PLL locked; asynchronous to refclk
- force_relock_i  in  1  single-cycle request to restart the PLL
- clear_fault_i  in  1  single-cycle request to leave FAULT
- pll_rst_o  out  1  PLL reset, active high
- sys_rst_n_o  out  1  qualified downstream reset, active low
- ready_o  out  1  PLL locked and qualified
- fault_o  out  1  retry budget exhausted
- relock_count_o  out  CNT_W  saturating count of loss-of-lock events in RUN

Behaviour:
- Reset is asynchronous and active-low; one clock domain (refclk). All outputs are registered.
- Reset values: pll_rst_o=1, sys_rst_n_o=0, ready_o=0, fault_o=0, relock_count_o=0, state=RESET_PLL, timer=0, retry=0.
- Synchronizer: pll_locked_i passes through 2 flops to give lk_s, adding 2 cycles of latency. The synchronizer flops reset to 0.
- Timer: one shared up-counter sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES); cleared on every state change.
- RESET_PLL: pll_rst_o=1. After exactly RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst_o=0.
  - lk_s=1: go to STABLE.
  - timer reaches LOCK_TIMEOUT-1 with lk_s=0: retry++. If retry==MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
- STABLE:
  - lk_s=0: return to WAIT_LOCK with the timer cleared; retry is not incremented.
  - STABLE_CYCLES consecutive high cycles: go to RUN and clear retry.
- RUN: ready_o=1 and sys_rst_n_o=1, both rising on the first cycle in RUN.
  - lk_s=0: relock_count_o increments, saturating at all-ones; go to RESET_PLL. ready_o and sys_rst_n_o drop on that same edge.
- FAULT: pll_rst_o=1, fault_o=1, sys_rst_n_o=0, ready_o=0. Only clear_fault_i exits, going to RESET_PLL with retry=0 and fault_o=0.
- force_relock_i in any state except FAULT: go to RESET_PLL and clear the timer. relock_count_o is not incremented and retry is unchanged. In FAULT, force_relock_i is ignored.
- Simultaneous force_relock_i and lk_s=0 in RUN: treated as a loss, so the count increments.
- rst_n asserted mid-operation: every output returns immediately (asynchronously) to its reset value. relock_count_o is cleared.

Optional Feature:
- Macro: CLK125_PLL_CTRL_LOSS_FILTER_EN.
- Defined: in RUN, loss is declared only after lk_s=0 for GLITCH_CYCLES consecutive cycles. Shorter drops are ignored and have no effect on outputs or count. The filter counter clears whenever lk_s=1.
- Undefined: a single low cycle of lk_s in RUN is a loss. GLITCH_CYCLES is unused.

Decomposition:
- Package clk125_pll_ctrl_pkg: state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT) and a clog2-based timer-width function.
- One sub-module, clk125_pll_ctrl_sync2: the 2-flop async-reset synchronizer, reused for the locked input.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2):
- Reset release, pll_locked_i rises 3 cycles after pll_rst_o falls:
  - pll_rst_o is high for exactly 4 cycles.
  - ready_o and sys_rst_n_o rise 2+8 cycles after the lock edge, give or take the state-entry cycle. Check cycle-exactly against the model.
- pll_locked_i held 0:
  - Two 20-cycle WAIT_LOCK windows, each preceded by a 4-cycle pll_rst_o pulse.
  - Then fault_o=1 with pll_rst_o held high.
  - clear_fault_i restarts the sequence with fault_o=0.
- In RUN, drop pll_locked_i 4 times:
  - relock_count_o steps 1, 2, 3, 3 (saturates).
  - ready_o drops 3 cycles after each falling edge.
- pll_locked_i low for 2 cycles during STABLE: returns to WAIT_LOCK; the full 8-cycle qualification restarts; relock_count_o is unchanged.
- force_relock_i pulse in RUN: pll_rst_o pulses for 4 cycles, ready_o drops on the next edge, relock_count_o is unchanged. force_relock_i in FAULT: no effect.
- With CLK125_PLL_CTRL_LOSS_FILTER_EN and GLITCH_CYCLES=8:
  - A 5-cycle drop in RUN leaves ready_o=1.
  - A 10-cycle drop clears ready_o 2+8 cycles after the falling edge.
